// File: rtl/ad_pkg.sv
// ad_pkg -- shared definitions for the dual-ADC capture scheduler.
//
// Contents:
//   ADC_W        sample width of both AD9226 channels
//   ADC_MIDSCALE offset-binary midscale code, a sensible default trig_level
//   cap_state_t  capture FSM state encoding
package ad_pkg;

   localparam int ADC_W = 12;

   localparam logic [ADC_W-1:0] ADC_MIDSCALE = 12'h800;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } cap_state_t;

endpackage

// File: rtl/knob_avg.sv
// Periodic sampler and block averager for the control potentiometer channel.
//
// Takes one sample of din every KNOB_PERIOD clocks, sums 2**AVG_LOG2 of them,
// then publishes the truncated mean on val with a one-cycle valid pulse.
//
// Ports:
//   clk    in   sample clock
//   rst    in   asynchronous active-high reset
//   din    in   ADC_W  registered potentiometer sample
//   val    out  ADC_W  latest block average
//   valid  out  1      pulses for one cycle when val updates
module knob_avg
   import ad_pkg::*;
#(
   parameter int KNOB_PERIOD = 65000,
   parameter int AVG_LOG2    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADC_W-1:0] din,
   output logic [ADC_W-1:0] val,
   output logic             valid
);

   localparam int PCNT_W = (KNOB_PERIOD > 2) ? $clog2(KNOB_PERIOD) : 1;
   localparam int ACC_W  = ADC_W + AVG_LOG2;
   localparam int CNT_W  = AVG_LOG2 + 1;

   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(KNOB_PERIOD - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(2 ** AVG_LOG2);

   logic [PCNT_W-1:0] pcnt;
   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt  <= '0;
         acc   <= '0;
         cnt   <= '0;
         val   <= '0;
         valid <= 1'b0;
      end else begin
         valid <= 1'b0;

         if (pcnt == PCNT_LAST) pcnt <= '0;
         else                   pcnt <= pcnt + 1'b1;

         // The publish cycle can never coincide with a sample tick because
         // KNOB_PERIOD >= 2, so no sample is lost when the accumulator clears.
         if (cnt == CNT_FULL) begin
            val   <= acc[ACC_W-1:AVG_LOG2];
            valid <= 1'b1;
            acc   <= '0;
            cnt   <= '0;
         end else if (pcnt == PCNT_LAST) begin
            acc <= acc + ACC_W'(din);
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ad_capture_sched.sv
// ad_capture_sched -- capture scheduler for the dual-AD9226 front end.
//
// Channel 1 (control potentiometer) is block-averaged by a sub-module.
// Channel 2 is armed by start, waits for a rising crossing of trig_level,
// then streams a decimated window of 2**ADDR_W samples into the sample RAM
// write port.
//
// Optional build macro AD_CAPTURE_SCHED_TRIG_TIMEOUT_EN: when defined, an ARM
// that sees no crossing for TIMEOUT cycles auto-triggers on the current sample.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | nothing armed since reset
// ARM     | waiting for a rising crossing of trig_level
// CAPTURE | writing decimated samples, addresses 0..DEPTH-1
// DONE    | window complete; start re-arms
module ad_capture_sched
   import ad_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int KNOB_PERIOD = 65000,
   parameter int AVG_LOG2    = 4,
   parameter int TIMEOUT     = 1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADC_W-1:0]  ad1_data,
   input  logic [ADC_W-1:0]  ad2_data,
   input  logic              start,
   input  logic [ADC_W-1:0]  trig_level,
   input  logic [7:0]        decim,
   output logic [ADC_W-1:0]  knob_val,
   output logic              knob_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADC_W-1:0]  wr_data,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

   logic [ADC_W-1:0]  ad1_q;
   logic [ADC_W-1:0]  ad2_q;
   logic [ADC_W-1:0]  prev2;
   cap_state_t        state;
   cap_state_t        state_nxt;
   logic [7:0]        decim_r;
   logic [7:0]        dcnt;
   logic [ADDR_W-1:0] addr_cnt;
   logic              crossing;
   logic              trigger;
   logic              arm_go;
   logic              do_wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ad1_q <= '0;
         ad2_q <= '0;
         prev2 <= '0;
      end else begin
         ad1_q <= ad1_data;
         ad2_q <= ad2_data;
         prev2 <= ad2_q;
      end
   end

   // Equal-to-level counts as crossed; a signal already above the level
   // on both samples does not.
   assign crossing = (prev2 < trig_level) && (ad2_q >= trig_level);

`ifdef AD_CAPTURE_SCHED_TRIG_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] arm_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                arm_cnt <= '0;
      else if (state == ARM)  arm_cnt <= arm_cnt + 1'b1;
      else                    arm_cnt <= '0;
   end

   assign trigger = crossing || (arm_cnt == TO_LAST);
`else
   assign trigger = crossing;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      arm_go    = 1'b0;
      do_wr     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = ARM;
               arm_go    = 1'b1;
            end
         end
         ARM: begin
            if (trigger) begin
               state_nxt = CAPTURE;
               do_wr     = 1'b1;
            end
         end
         CAPTURE: begin
            // The visible write of the last address ends the window; leave
            // before addr_cnt wraps.
            if (wr_en && (wr_addr == ADDR_LAST)) state_nxt = DONE;
            else if (dcnt == decim_r)            do_wr     = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == ARM) || (state == CAPTURE);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         decim_r  <= '0;
         dcnt     <= '0;
         addr_cnt <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         wr_en <= 1'b0;
         if (arm_go) begin
            decim_r  <= decim;
            dcnt     <= '0;
            addr_cnt <= '0;
         end
         if (do_wr) begin
            wr_en    <= 1'b1;
            wr_addr  <= addr_cnt;
            wr_data  <= ad2_q;
            addr_cnt <= addr_cnt + 1'b1;
            dcnt     <= '0;
         end else if (state == CAPTURE) begin
            dcnt <= dcnt + 1'b1;
         end
      end
   end

   knob_avg #(
      .KNOB_PERIOD (KNOB_PERIOD),
      .AVG_LOG2    (AVG_LOG2)
   ) u_knob_avg (
      .clk   (clk),
      .rst   (rst),
      .din   (ad1_q),
      .val   (knob_val),
      .valid (knob_valid)
   );

endmodule

// File: tb/tb_ad_capture_sched.sv
module tb_ad_capture_sched;
   import ad_pkg::*;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;
   localparam int KP     = 4;
   localparam int AL     = 2;
   localparam int TO     = 50;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [11:0]       ad1 = '0;
   logic [11:0]       ad2 = '0;
   logic              start = 1'b0;
   logic [11:0]       trig_level = ADC_MIDSCALE;
   logic [7:0]        decim = '0;
   logic [11:0]       avg_val;
   logic              avg_valid;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [11:0]       wr_data;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic        ramp_en  = 1'b1;
   logic [11:0] ad2_hold = '0;
   logic        pot_alt  = 1'b0;
   logic [11:0] ad1_hold = '0;
   int          kdiv     = 0;

   ad_capture_sched #(
      .ADDR_W      (ADDR_W),
      .KNOB_PERIOD (KP),
      .AVG_LOG2    (AL),
      .TIMEOUT     (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ad1_data   (ad1),
      .ad2_data   (ad2),
      .start      (start),
      .trig_level (trig_level),
      .decim      (decim),
      .knob_val   (avg_val),
      .knob_valid (avg_valid),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ADC stimulus changes on the falling edge, away from DUT sampling.
   always @(negedge clk) begin
      if (ramp_en) ad2 = ad2 + 12'd1;
      else         ad2 = ad2_hold;
      if (pot_alt) begin
         if (kdiv == 3) begin
            kdiv = 0;
            ad1  = (ad1 == 12'd0) ? 12'd3 : 12'd0;
         end else begin
            kdiv++;
         end
      end else begin
         kdiv = 0;
         ad1  = ad1_hold;
      end
   end

   task automatic pulse_start(input logic [7:0] d);
      @(negedge clk);
      decim = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Monitors one capture from ARM to DONE against a ramp that crossed at
   // 2048. Optionally pulses start right after the write of address glitch.
   task automatic run_capture(input int d, input int glitch, input string tag);
      int          nw;
      int          last;
      bit          fin;
      logic [11:0] exp_d;
      nw = 0; last = 0; fin = 0;
      for (int i = 0; i < 20000 && !fin; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            fin = 1;
            checks++;
            if (nw !== DEPTH) begin
               errors++;
               $display("FAIL %s write_count: got %0d expected %0d", tag, nw, DEPTH);
            end
            checks++;
            if (cyc - last !== 1) begin
               errors++;
               $display("FAIL %s done_latency: got %0d cycles expected 1", tag, cyc - last);
            end
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL %s busy_in_done: got %b expected 0", tag, busy);
            end
         end else begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL %s busy: got %b expected 1 (write %0d)", tag, busy, nw);
            end
            if (wr_en) begin
               exp_d = 12'(2048 + nw * (d + 1));
               checks++;
               if (wr_addr !== ADDR_W'(nw)) begin
                  errors++;
                  $display("FAIL %s wr_addr: got %0d expected %0d", tag, wr_addr, nw);
               end
               checks++;
               if (wr_data !== exp_d) begin
                  errors++;
                  $display("FAIL %s wr_data[%0d]: got %0d expected %0d", tag, nw, wr_data, exp_d);
               end
               if (nw > 0) begin
                  checks++;
                  if (cyc - last !== d + 1) begin
                     errors++;
                     $display("FAIL %s write_gap: got %0d expected %0d", tag, cyc - last, d + 1);
                  end
               end
               last = cyc;
               if (nw == glitch) start = 1'b1;
               nw++;
            end
         end
      end
      if (!fin) begin
         errors++;
         $display("FAIL %s timeout: done not seen, %0d writes", tag, nw);
      end
   endtask

   task automatic test_reset(output int rel);
      rst      = 1'b1;
      ad1_hold = 12'd1234;
      ramp_en  = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({wr_en, wr_addr, wr_data, busy, done, avg_val, avg_valid} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got wr_en=%b addr=%0d data=%0d busy=%b done=%b avg=%0d av=%b expected all 0",
                  wr_en, wr_addr, wr_data, busy, done, avg_val, avg_valid);
      end
      rst = 1'b0;
      rel = cyc;
   endtask

   task automatic test_avg_const(input int rel);
      int v1, v2;
      v1 = -1; v2 = -1;
      for (int i = 0; i < 60 && v2 < 0; i++) begin
         @(posedge clk); #1;
         if (v1 >= 0 && cyc == v1 + 1) begin
            checks++;
            if (avg_valid !== 1'b0) begin
               errors++;
               $display("FAIL avg_valid_width: got %b expected 0", avg_valid);
            end
         end
         if (avg_valid) begin
            checks++;
            if (avg_val !== 12'd1234) begin
               errors++;
               $display("FAIL avg_val_const: got %0d expected 1234", avg_val);
            end
            if (v1 < 0) v1 = cyc;
            else        v2 = cyc;
         end
      end
      if (v2 < 0) begin
         errors++;
         $display("FAIL avg_timeout: got %0d pulses expected 2", (v1 < 0) ? 0 : 1);
      end else begin
         checks++;
         if (v1 - rel !== 17) begin
            errors++;
            $display("FAIL avg_first_latency: got %0d expected 17", v1 - rel);
         end
         checks++;
         if (v2 - v1 !== 16) begin
            errors++;
            $display("FAIL avg_period: got %0d expected 16", v2 - v1);
         end
      end
   endtask

   task automatic test_avg_trunc();
      int np;
      np = 0;
      pot_alt = 1'b1;
      for (int i = 0; i < 200 && np < 2; i++) begin
         @(posedge clk); #1;
         if (avg_valid) begin
            np++;
            if (np == 2) begin
               checks++;
               if (avg_val !== 12'd1) begin
                  errors++;
                  $display("FAIL avg_trunc: got %0d expected 1", avg_val);
               end
            end
         end
      end
      if (np < 2) begin
         errors++;
         $display("FAIL avg_trunc_timeout: got %0d pulses expected 2", np);
      end
      pot_alt = 1'b0;
   endtask

   task automatic test_ramp(input int d);
      pulse_start(8'(d));
      run_capture(d, -1, (d == 0) ? "ramp_d0" : "ramp_d3");
   endtask

   task automatic test_start_in_done();
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL pre_done: got %b expected 1", done);
      end
      @(negedge clk);
      decim = 8'd3;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({done, busy} !== 2'b01) begin
         errors++;
         $display("FAIL rearm_edge: got done=%b busy=%b expected done=0 busy=1", done, busy);
      end
      run_capture(3, -1, "rearm_d3");
   endtask

   task automatic test_start_during_capture();
      pulse_start(8'd0);
      run_capture(0, 100, "start_in_capture");
   endtask

   task automatic test_no_trigger();
      ramp_en  = 1'b0;
      ad2_hold = 12'd3000;
      repeat (4) @(negedge clk);
      pulse_start(8'd0);
`ifdef AD_CAPTURE_SCHED_TRIG_TIMEOUT_EN
      begin
         bit got;
         got = 0;
         for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            if (wr_en) begin
               got = 1;
               checks++;
               if (wr_addr !== '0) begin
                  errors++;
                  $display("FAIL auto_trig_addr: got %0d expected 0", wr_addr);
               end
               checks++;
               if (wr_data !== 12'd3000) begin
                  errors++;
                  $display("FAIL auto_trig_data: got %0d expected 3000", wr_data);
               end
            end
         end
         if (!got) begin
            errors++;
            $display("FAIL auto_trig_timeout: got no write expected one");
         end
      end
`else
      begin
         int bad_busy, bad_wr;
         bad_busy = 0; bad_wr = 0;
         repeat (200) begin
            @(posedge clk); #1;
            if (busy !== 1'b1) bad_busy++;
            if (wr_en !== 1'b0) bad_wr++;
         end
         checks++;
         if (bad_busy !== 0) begin
            errors++;
            $display("FAIL no_trig_busy: got %0d low cycles expected 0", bad_busy);
         end
         checks++;
         if (bad_wr !== 0) begin
            errors++;
            $display("FAIL no_trig_writes: got %0d writes expected 0", bad_wr);
         end
      end
`endif
   endtask

   task automatic test_reset_mid();
      bit found;
      int bad;
      found = 0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      ramp_en = 1'b1;
      pulse_start(8'd0);
      for (int i = 0; i < 10000 && !found; i++) begin
         @(posedge clk); #1;
         if (wr_en && wr_addr == 10'd500) found = 1;
      end
      if (!found) begin
         errors++;
         $display("FAIL reset_mid_timeout: got no write at addr 500");
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({wr_en, wr_addr, wr_data, busy, done, avg_val, avg_valid} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got wr_en=%b addr=%0d data=%0d busy=%b done=%b avg=%0d expected all 0",
                  wr_en, wr_addr, wr_data, busy, done, avg_val);
      end
      @(negedge clk); rst = 1'b0;
      bad = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if ({done, busy, wr_en} !== 3'b000) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL post_reset_idle: got %0d active cycles expected 0", bad);
      end
      pulse_start(8'd0);
      run_capture(0, -1, "after_reset");
   endtask

   initial begin
      int rel;
      trig_level = ADC_MIDSCALE;
      test_reset(rel);
      test_avg_const(rel);
      test_avg_trunc();
      ad1_hold = 12'd1234;
      test_ramp(0);
      test_start_in_done();
      test_start_during_capture();
      test_no_trigger();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
